uart_sha_host: RTL and testbench
================================

Name: uart_sha_host

Overview:
- Host-side initiator for the UART SHA job protocol: drives the byte stream that the FPGA SHA farm consumes, and parses the farm's replies.
- Takes one job as a parallel word, serialises it over a uart_tx byte interface, collects replies from a uart_rx byte interface, and returns found/exhausted plus the nonce.
- Used as a bench driver for the farm and for chaining boards (one FPGA dispatching jobs to another).

Parameters:
- TIMEOUT_CYCLES, 10_000_000, maximum idle cycles while waiting for a handshake reply ('1', 'S', 'O', or a nonce byte).
- HASH_TIMEOUT_CYCLES, 0, maximum cycles waiting for 'Y'/'N'; 0 disables the timeout.

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- job_valid  in  1  job offered
- job_ready  out  1  high only in IDLE
- job_header  in  96  12 data bytes
- job_state  in  256  midstate
- job_target  in  256  target
- job_nonce_base  in  32  starting nonce
- job_position  in  32  nonce byte position
- abort  in  1  single-cycle pulse: reset the remote farm
- tx_data  out  8  byte to uart_tx
- tx_valid  out  1  byte offered
- tx_ready  in  1  uart_tx accepts the byte
- rx_data  in  8  byte from uart_rx
- rx_valid  in  1  single-cycle strobe: byte received
- res_valid  out  1  single-cycle result strobe
- res_found  out  1  1 = 'Y', 0 = 'N'
- res_nonce  out  32  nonce, LSB byte received first
- res_err  out  2  0 ok, 1 unexpected byte, 2 timeout, 3 remote error ('E'/'e')
- busy  out  1  state != IDLE

Behaviour:
- Reset: state IDLE. All outputs 0, except job_ready = 1. Internal counters cleared.
- Byte handshake: a byte transfers on a cycle where tx_valid & tx_ready. tx_data is stable while tx_valid is high. At most one byte is in flight.
- IDLE, job_valid & job_ready: latch all job fields. Go to SEND_HELLO.
- IDLE, abort: go to SEND_RESET.
- SEND_HELLO: tx 'H', then WAIT_ACK.
- WAIT_ACK: rx '1' -> SEND_JOB.
- SEND_JOB: byte counter 0..83. Each field is sent least-significant byte first:
  - bytes 0-11: header
  - bytes 12-43: state
  - bytes 44-75: target
  - bytes 76-79: nonce_base
  - bytes 80-83: position
  - After byte 83 transfers -> WAIT_START.
- WAIT_START: rx 'S' -> WAIT_RESULT.
- WAIT_RESULT: rx 'Y' or 'N' -> record found. Go to RECV_NONCE with count 0.
- RECV_NONCE: 4 bytes; byte k -> res_nonce[8k+:8]. After the 4th byte, pulse res_valid with err 0, then IDLE.
- Trailing bytes: the farm may emit a fifth trailing byte. Any byte arriving in IDLE is discarded silently, with no error.
- SEND_RESET: tx 'R', then WAIT_RESET. rx 'O' -> IDLE, no res_valid.
- Abort while busy: abort in any state other than IDLE or SEND_RESET goes to SEND_RESET. If a tx byte is pending (tx_valid high, not yet accepted), it is dropped: tx_valid falls in the next cycle. abort in SEND_RESET or WAIT_RESET is ignored.
- Error, any waiting state:
  - rx 'E' or 'e' -> res_err = 3.
  - Any other unexpected byte -> res_err = 1.
  - Either case: pulse res_valid, res_found = 0, then SEND_RESET.
  - Exception: in WAIT_RESET, unexpected bytes are ignored.
- Timeout:
  - The wait counter clears on state entry and on every rx_valid.
  - Reaching TIMEOUT_CYCLES in WAIT_ACK, WAIT_START, RECV_NONCE or WAIT_RESET -> res_err = 2, pulse res_valid, then IDLE.
  - In WAIT_RESULT the counter is compared against HASH_TIMEOUT_CYCLES when that is nonzero.
- Simultaneous events: rx_valid and timeout in the same cycle -> the byte wins. abort and an rx byte in the same cycle -> abort wins.
- Output hold: res_found, res_nonce and res_err hold until the next res_valid.
- Reset mid-operation: asynchronous return to reset values; no bytes are emitted.

Test Plan:
- Happy path. Job with header bytes 0x00..0x0B, nonce_base 0x11223344, position 0x0C. Farm replies '1', 'S', 'Y', 0x78, 0x56, 0x34, 0x12. Required:
  - tx sequence 'H' followed by 84 bytes, with byte 76 = 0x44 and byte 79 = 0x11.
  - res_valid once, found = 1, nonce = 0x12345678, err = 0.
- Exhausted. Reply 'N' plus 4 bytes -> found = 0, err = 0. A fifth trailing byte in IDLE produces no res_valid.
- tx backpressure. tx_ready low for 5 cycles on every byte -> tx_data stable throughout; same 85-byte sequence.
- Remote error. 'E' received in WAIT_ACK -> res_err = 3. The host then sends 'R'; reply 'O' -> IDLE, job_ready = 1.
- Timeout. TIMEOUT_CYCLES = 100, no reply after 'H' -> res_valid in cycle 100 after entry, err = 2.
- Abort / async reset:
  - abort during SEND_JOB byte 40 -> next tx byte is 'R'.
  - rstn low mid-job -> tx_valid = 0 and job_ready = 1 immediately.

Source files
------------

// File: rtl/uart_sha_host_if.sv
// Job, UART byte and result signals shared by the UART SHA host and the block that drives it.
interface uart_sha_host_if;
    logic         job_valid;
    logic         job_ready;
    logic [95:0]  job_header;
    logic [255:0] job_state;
    logic [255:0] job_target;
    logic [31:0]  job_nonce_base;
    logic [31:0]  job_position;
    logic         abort;
    logic [7:0]   tx_data;
    logic         tx_valid;
    logic         tx_ready;
    logic [7:0]   rx_data;
    logic         rx_valid;
    logic         res_valid;
    logic         res_found;
    logic [31:0]  res_nonce;
    logic [1:0]   res_err;
    logic         busy;

    modport slave (
        input  job_valid, job_header, job_state, job_target, job_nonce_base, job_position,
        input  abort, tx_ready, rx_data, rx_valid,
        output job_ready, tx_data, tx_valid, res_valid, res_found, res_nonce, res_err, busy
    );

    modport master (
        output job_valid, job_header, job_state, job_target, job_nonce_base, job_position,
        output abort, tx_ready, rx_data, rx_valid,
        input  job_ready, tx_data, tx_valid, res_valid, res_found, res_nonce, res_err, busy
    );
endinterface

// File: rtl/uart_sha_host.sv
// Host-side UART SHA job initiator: serialises one job to the farm over a byte
// stream and parses the farm's handshake, result and nonce replies.
module uart_sha_host #(
    parameter int unsigned TIMEOUT_CYCLES      = 10_000_000,
    parameter int unsigned HASH_TIMEOUT_CYCLES = 0
) (
    input  logic           clk,
    input  logic           rstn,
    uart_sha_host_if.slave host_if
);
    typedef enum logic [3:0] {
        S_IDLE, S_SEND_HELLO, S_WAIT_ACK, S_SEND_JOB, S_WAIT_START,
        S_WAIT_RESULT, S_RECV_NONCE, S_SEND_RESET, S_WAIT_RESET
    } state_e;

    localparam logic [7:0]  CH_H  = 8'h48;
    localparam logic [7:0]  CH_1  = 8'h31;
    localparam logic [7:0]  CH_S  = 8'h53;
    localparam logic [7:0]  CH_Y  = 8'h59;
    localparam logic [7:0]  CH_N  = 8'h4E;
    localparam logic [7:0]  CH_R  = 8'h52;
    localparam logic [7:0]  CH_O  = 8'h4F;
    localparam logic [7:0]  CH_EU = 8'h45;
    localparam logic [7:0]  CH_EL = 8'h65;
    localparam logic [6:0]  LAST_JOB_BYTE = 7'd83;
    localparam logic [31:0] TO_LAST   = 32'(TIMEOUT_CYCLES - 1);
    localparam logic [31:0] HASH_LAST = 32'(HASH_TIMEOUT_CYCLES - 1);

    state_e       state_q;
    logic [671:0] job_q;
    logic [6:0]   cnt_q;
    logic [31:0]  wait_q;
    logic [7:0]   tx_data_q;
    logic         tx_valid_q;
    logic         res_valid_q;
    logic         res_found_q;
    logic         found_acc_q;
    logic [23:0]  nonce_acc_q;
    logic [31:0]  res_nonce_q;
    logic [1:0]   res_err_q;

    logic tx_fire, waiting, rx_ok, timed_out, bad_byte, abort_hit;

    function automatic logic [1:0] err_code(input logic [7:0] b);
        return ((b == CH_EU) || (b == CH_EL)) ? 2'd3 : 2'd1;
    endfunction

    always_comb begin
        tx_fire   = tx_valid_q & host_if.tx_ready;
        waiting   = state_q inside {S_WAIT_ACK, S_WAIT_START, S_WAIT_RESULT, S_RECV_NONCE, S_WAIT_RESET};
        rx_ok     = 1'b1;
        unique case (state_q)
            S_WAIT_ACK:    rx_ok = (host_if.rx_data == CH_1);
            S_WAIT_START:  rx_ok = (host_if.rx_data == CH_S);
            S_WAIT_RESULT: rx_ok = (host_if.rx_data == CH_Y) || (host_if.rx_data == CH_N);
            default:       rx_ok = 1'b1;
        endcase
        // The hash wait has its own, optionally disabled, limit.
        if (state_q == S_WAIT_RESULT)
            timed_out = (HASH_TIMEOUT_CYCLES != 0) && (wait_q == HASH_LAST);
        else
            timed_out = waiting && (wait_q == TO_LAST);
        bad_byte  = host_if.rx_valid && !rx_ok;
        abort_hit = host_if.abort && !(state_q inside {S_IDLE, S_SEND_RESET, S_WAIT_RESET});
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= S_IDLE;
            job_q       <= '0;
            cnt_q       <= '0;
            wait_q      <= '0;
            tx_data_q   <= '0;
            tx_valid_q  <= 1'b0;
            res_valid_q <= 1'b0;
            res_found_q <= 1'b0;
            found_acc_q <= 1'b0;
            nonce_acc_q <= '0;
            res_nonce_q <= '0;
            res_err_q   <= '0;
        end else begin
            res_valid_q <= 1'b0;
            // Non-waiting states hold the counter at zero, so every wait starts fresh.
            wait_q      <= (waiting && !host_if.rx_valid) ? wait_q + 32'd1 : '0;
            if (abort_hit) begin
                tx_valid_q <= 1'b0;
                state_q    <= S_SEND_RESET;
            end else if (bad_byte) begin
                res_valid_q <= 1'b1;
                res_found_q <= 1'b0;
                res_err_q   <= err_code(host_if.rx_data);
                state_q     <= S_SEND_RESET;
            end else if (timed_out && !host_if.rx_valid) begin
                res_valid_q <= 1'b1;
                res_found_q <= 1'b0;
                res_err_q   <= 2'd2;
                state_q     <= S_IDLE;
            end else begin
                unique case (state_q)
                    S_IDLE: begin
                        if (host_if.job_valid) begin
                            job_q      <= {host_if.job_position, host_if.job_nonce_base, host_if.job_target,
                                           host_if.job_state, host_if.job_header};
                            tx_data_q  <= CH_H;
                            tx_valid_q <= 1'b1;
                            state_q    <= S_SEND_HELLO;
                        end else if (host_if.abort) begin
                            state_q <= S_SEND_RESET;
                        end
                    end
                    S_SEND_HELLO: begin
                        if (tx_fire) begin
                            tx_valid_q <= 1'b0;
                            state_q    <= S_WAIT_ACK;
                        end
                    end
                    S_WAIT_ACK: begin
                        if (host_if.rx_valid) begin
                            tx_data_q  <= job_q[7:0];
                            tx_valid_q <= 1'b1;
                            cnt_q      <= '0;
                            state_q    <= S_SEND_JOB;
                        end
                    end
                    S_SEND_JOB: begin
                        if (tx_fire) begin
                            if (cnt_q == LAST_JOB_BYTE) begin
                                tx_valid_q <= 1'b0;
                                state_q    <= S_WAIT_START;
                            end else begin
                                job_q     <= {8'h00, job_q[671:8]};
                                tx_data_q <= job_q[15:8];
                                cnt_q     <= cnt_q + 7'd1;
                            end
                        end
                    end
                    S_WAIT_START: begin
                        if (host_if.rx_valid) state_q <= S_WAIT_RESULT;
                    end
                    S_WAIT_RESULT: begin
                        if (host_if.rx_valid) begin
                            found_acc_q <= (host_if.rx_data == CH_Y);
                            cnt_q       <= '0;
                            state_q     <= S_RECV_NONCE;
                        end
                    end
                    S_RECV_NONCE: begin
                        // Nonce arrives LSB first; the result registers only change on completion.
                        if (host_if.rx_valid) begin
                            if (cnt_q == 7'd3) begin
                                res_valid_q <= 1'b1;
                                res_found_q <= found_acc_q;
                                res_nonce_q <= {host_if.rx_data, nonce_acc_q};
                                res_err_q   <= 2'd0;
                                state_q     <= S_IDLE;
                            end else begin
                                nonce_acc_q <= {host_if.rx_data, nonce_acc_q[23:8]};
                                cnt_q       <= cnt_q + 7'd1;
                            end
                        end
                    end
                    S_SEND_RESET: begin
                        if (!tx_valid_q) begin
                            tx_data_q  <= CH_R;
                            tx_valid_q <= 1'b1;
                        end else if (tx_fire) begin
                            tx_valid_q <= 1'b0;
                            state_q    <= S_WAIT_RESET;
                        end
                    end
                    S_WAIT_RESET: begin
                        if (host_if.rx_valid && (host_if.rx_data == CH_O)) state_q <= S_IDLE;
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign host_if.job_ready = (state_q == S_IDLE);
    assign host_if.busy      = (state_q != S_IDLE);
    assign host_if.tx_data   = tx_data_q;
    assign host_if.tx_valid  = tx_valid_q;
    assign host_if.res_valid = res_valid_q;
    assign host_if.res_found = res_found_q;
    assign host_if.res_nonce = res_nonce_q;
    assign host_if.res_err   = res_err_q;
endmodule

// File: tb/tb_uart_sha_host.sv
// Scoreboard bench for uart_sha_host: directed farm replies drive the host while a
// monitor pops expected tx bytes and results as the host presents them.
module tb_uart_sha_host;
    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    uart_sha_host_if dif();

    uart_sha_host #(
        .TIMEOUT_CYCLES     (100),
        .HASH_TIMEOUT_CYCLES(0)
    ) dut (
        .clk    (clk),
        .rstn   (rstn),
        .host_if(dif)
    );

    typedef struct {
        logic        found;
        logic [31:0] nonce;
        logic [1:0]  err;
        bit          lat;
    } res_t;

    logic [7:0] exp_tx[$];
    res_t       exp_res[$];
    int n_total  = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int h_cyc    = 0;
    int rdy_mode = 0;
    logic       prev_pend = 1'b0;
    logic [7:0] prev_data = 8'h00;

    always @(posedge clk) cyc++;

    // Byte j of the job stream, written out field by field.
    function automatic logic [7:0] job_byte(input int j);
        logic [7:0] b;
        if (j < 12)      b = 8'(j);
        else if (j < 44) b = 8'(32'h20 + j - 12);
        else if (j < 76) b = 8'(32'h80 + j - 44);
        else begin
            case (j)
                76:      b = 8'h44;
                77:      b = 8'h33;
                78:      b = 8'h22;
                79:      b = 8'h11;
                80:      b = 8'h0C;
                default: b = 8'h00;
            endcase
        end
        return b;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic fail_now(input string name, input string what);
        n_total++;
        $display("FAIL %s: %s", name, what);
    endtask

    always @(negedge clk) begin : monitor
        res_t e;
        if (!rstn) begin
            prev_pend = 1'b0;
        end else begin
            if (dif.tx_valid && prev_pend) check("tx_stable", 32'(dif.tx_data), 32'(prev_data));
            if (dif.tx_valid && dif.tx_ready) begin
                if (exp_tx.size() == 0) fail_now("tx_unexpected", $sformatf("byte 0x%02h sent, none expected", dif.tx_data));
                else check("tx_byte", 32'(dif.tx_data), 32'(exp_tx.pop_front()));
                if (dif.tx_data == 8'h48) h_cyc = cyc;
            end
            prev_pend = dif.tx_valid && !dif.tx_ready;
            prev_data = dif.tx_data;
            if (dif.res_valid) begin
                if (exp_res.size() == 0) begin
                    fail_now("res_unexpected", $sformatf("res_valid with err %0d, none expected", dif.res_err));
                end else begin
                    e = exp_res.pop_front();
                    check("res_found", 32'(dif.res_found), 32'(e.found));
                    check("res_nonce", dif.res_nonce, e.nonce);
                    check("res_err", 32'(dif.res_err), 32'(e.err));
                    // 'H' seen on the negedge before its transfer edge: entry + 100 cycles.
                    if (e.lat) check("timeout_latency", 32'(cyc - h_cyc), 32'd101);
                end
            end
        end
    end

    initial begin : rdy_drv
        int hold;
        hold = 0;
        forever begin
            @(posedge clk);
            #1;
            if (rdy_mode == 0) begin
                dif.tx_ready = 1'b1;
            end else if (rdy_mode == 1) begin
                if (dif.tx_valid && hold < 5) begin
                    dif.tx_ready = 1'b0;
                    hold++;
                end else begin
                    dif.tx_ready = 1'b1;
                    hold = 0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_rx(input logic [7:0] b);
        dif.rx_data  = b;
        dif.rx_valid = 1'b1;
        tick();
        dif.rx_valid = 1'b0;
    endtask

    task automatic offer_job();
        exp_tx.push_back(8'h48);
        dif.job_valid = 1'b1;
        tick();
        dif.job_valid = 1'b0;
    endtask

    task automatic push_job(input int first, input int last);
        for (int j = first; j <= last; j++) exp_tx.push_back(job_byte(j));
    endtask

    task automatic expect_res(input logic found, input logic [31:0] nonce, input logic [1:0] err, input bit lat);
        res_t r;
        r.found = found;
        r.nonce = nonce;
        r.err   = err;
        r.lat   = lat;
        exp_res.push_back(r);
    endtask

    task automatic drain_tx(input string name, input int budget);
        int n;
        n = 0;
        while (exp_tx.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        if (exp_tx.size() != 0) begin
            fail_now(name, $sformatf("%0d expected tx bytes never sent", exp_tx.size()));
            exp_tx.delete();
        end
    endtask

    task automatic drain_res(input string name, input int budget);
        int n;
        n = 0;
        while (exp_res.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        if (exp_res.size() != 0) begin
            fail_now(name, $sformatf("%0d expected results never presented", exp_res.size()));
            exp_res.delete();
        end
    endtask

    task automatic full_job(input logic [7:0] yn, input logic [31:0] nonce);
        offer_job();
        drain_tx("hello_sent", 1000);
        push_job(0, 83);
        send_rx(8'h31);
        drain_tx("job_sent", 1000);
        expect_res(yn == 8'h59, nonce, 2'd0, 1'b0);
        send_rx(8'h53);
        send_rx(yn);
        for (int k = 0; k < 4; k++) send_rx(nonce[8*k +: 8]);
        drain_res("result", 20);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: bench did not reach its summary");
        $fatal(1, "bench stalled");
    end

    initial begin
        dif.job_valid      = 1'b0;
        dif.abort          = 1'b0;
        dif.tx_ready       = 1'b1;
        dif.rx_data        = 8'h00;
        dif.rx_valid       = 1'b0;
        dif.job_header     = 96'h0B0A_0908_0706_0504_0302_0100;
        for (int i = 0; i < 32; i++) begin
            dif.job_state[8*i +: 8]  = 8'(32'h20 + i);
            dif.job_target[8*i +: 8] = 8'(32'h80 + i);
        end
        dif.job_nonce_base = 32'h1122_3344;
        dif.job_position   = 32'h0000_000C;

        repeat (3) @(posedge clk);
        #1;
        check("rst_job_ready", 32'(dif.job_ready), 32'd1);
        check("rst_tx_valid", 32'(dif.tx_valid), 32'd0);
        check("rst_res_valid", 32'(dif.res_valid), 32'd0);
        check("rst_busy", 32'(dif.busy), 32'd0);
        check("rst_res_err", 32'(dif.res_err), 32'd0);
        check("rst_res_nonce", dif.res_nonce, 32'd0);
        rstn = 1'b1;
        tick();

        // Happy path and exhausted job with a trailing byte in IDLE.
        full_job(8'h59, 32'h1234_5678);
        full_job(8'h4E, 32'hDEAD_BEEF);
        send_rx(8'h99);
        repeat (5) tick();
        check("trail_busy", 32'(dif.busy), 32'd0);
        check("trail_hold_nonce", dif.res_nonce, 32'hDEAD_BEEF);

        // Five cycles of backpressure on every byte.
        rdy_mode = 1;
        full_job(8'h59, 32'hCAFE_F00D);
        rdy_mode = 0;

        // Remote error in WAIT_ACK, then the reset handshake.
        offer_job();
        drain_tx("err_hello", 20);
        expect_res(1'b0, 32'hCAFE_F00D, 2'd3, 1'b0);
        send_rx(8'h45);
        drain_res("err_result", 20);
        exp_tx.push_back(8'h52);
        drain_tx("err_reset_sent", 20);
        send_rx(8'h4F);
        check("err_job_ready", 32'(dif.job_ready), 32'd1);
        check("err_busy", 32'(dif.busy), 32'd0);

        // No reply after 'H'.
        offer_job();
        drain_tx("to_hello", 20);
        expect_res(1'b0, 32'hCAFE_F00D, 2'd2, 1'b1);
        drain_res("timeout_result", 150);
        check("to_job_ready", 32'(dif.job_ready), 32'd1);

        // Abort while job byte 40 is pending.
        rdy_mode = 2;
        dif.tx_ready = 1'b1;
        offer_job();
        drain_tx("abort_hello", 20);
        push_job(0, 39);
        send_rx(8'h31);
        drain_tx("abort_pre", 100);
        dif.tx_ready = 1'b0;
        dif.abort    = 1'b1;
        tick();
        dif.abort    = 1'b0;
        check("abort_drop", 32'(dif.tx_valid), 32'd0);
        exp_tx.push_back(8'h52);
        dif.tx_ready = 1'b1;
        drain_tx("abort_reset_sent", 20);
        send_rx(8'h4F);
        check("abort_job_ready", 32'(dif.job_ready), 32'd1);
        rdy_mode = 0;

        // Asynchronous reset in the middle of the job stream.
        offer_job();
        drain_tx("mid_hello", 20);
        push_job(0, 83);
        send_rx(8'h31);
        repeat (10) tick();
        #2;
        rstn = 1'b0;
        #1;
        check("mid_rst_tx_valid", 32'(dif.tx_valid), 32'd0);
        check("mid_rst_job_ready", 32'(dif.job_ready), 32'd1);
        check("mid_rst_busy", 32'(dif.busy), 32'd0);
        check("mid_rst_nonce", dif.res_nonce, 32'd0);
        exp_tx.delete();
        tick();
        rstn = 1'b1;
        repeat (3) tick();
        check("post_rst_tx_valid", 32'(dif.tx_valid), 32'd0);

        full_job(8'h59, 32'h0BAD_F00D);

        check("end_tx_queue", 32'(exp_tx.size()), 32'd0);
        check("end_res_queue", 32'(exp_res.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
